// File: rtl/or3_reduce_seq_if.sv
// ----------------------------------------------------------------------------
// or3_reduce_seq_if
// Handshake bundle for the OR3 reduction stage.
//   Input side : in_valid / in_ready / in_data[WIDTH-1:0]
//   Output side: out_valid / out_ready / out_any / out_first[IW-1:0] / busy
// Modports:
//   master - the side that supplies words and consumes results
//   slave  - the reduction stage itself
// ----------------------------------------------------------------------------
interface or3_reduce_seq_if #(
    parameter int WIDTH = 32
);
    localparam int NCHUNK = (WIDTH + 2) / 3;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_any;
    logic [IW-1:0]    out_first;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_any, out_first, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_any, out_first, busy
    );
endinterface

// File: rtl/or3_reduce_seq.sv
// ----------------------------------------------------------------------------
// or3_reduce_seq
// Multi-cycle OR reduction: a captured WIDTH-bit word is shifted through a
// 3-input OR, one 3-bit chunk per clock. Reports whether any bit was set and
// the index of the lowest chunk containing a set bit.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - or3_reduce_seq_if.slave (in_valid/in_ready/in_data,
//          out_valid/out_ready/out_any/out_first, busy)
//
// Optional build macro:
//   OR3_REDUCE_EARLY_EXIT_EN - when defined, the first set chunk ends the
//   scan immediately instead of walking all NCHUNK chunks.
// ----------------------------------------------------------------------------
module or3_reduce_seq #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    or3_reduce_seq_if.slave        bus
);
    localparam int NCHUNK = (WIDTH + 2) / 3;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SHW    = 3 * NCHUNK;
    localparam logic [IW-1:0] LAST_CNT = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [SHW-1:0]  r_sh;
    logic [IW-1:0]   r_cnt;
    logic            r_acc;
    logic [IW-1:0]   r_first;

    logic [SHW-1:0]  w_in_pad;
    logic            w_z;
    logic            w_accept;
    logic            w_last;

    // Zero-extend the input word to a whole number of chunks so the pad
    // bits can never contribute to the reduction.
    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_pad
            if (gi < WIDTH) begin : g_data
                assign w_in_pad[gi] = bus.in_data[gi];
            end else begin : g_zero
                assign w_in_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_z      = r_sh[0] | r_sh[1] | r_sh[2];
    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
`ifdef OR3_REDUCE_EARLY_EXIT_EN
                if (w_z || w_last) begin
                    w_state_next = DONE;
                end
`else
                if (w_last) begin
                    w_state_next = DONE;
                end
`endif
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                // Return to IDLE only; a new word is taken on the next edge.
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: shift register, chunk counter, accumulator, first-set index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh    <= '0;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_first <= '0;
        end else if (w_accept) begin
            r_sh    <= w_in_pad;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_first <= '0;
        end else if (r_state == RUN) begin
            // Only the first set chunk is recorded.
            if (w_z && !r_acc) begin
                r_first <= r_cnt;
            end
            r_acc <= r_acc | w_z;
            r_sh  <= r_sh >> 3;
            r_cnt <= r_cnt + IW'(1);
        end
    end

    // Result is only presented while the FSM is in DONE.
    assign bus.out_any   = (r_state == DONE) && r_acc;
    assign bus.out_first = r_first;

endmodule

// File: tb/tb_or3_reduce_seq.sv
// ----------------------------------------------------------------------------
// tb_or3_reduce_seq
// Directed bench for or3_reduce_seq at WIDTH=32 (NCHUNK=11, IW=4).
// Expected latencies follow the build: full 11-chunk scan by default, or the
// early-exit latency when OR3_REDUCE_EARLY_EXIT_EN is defined.
// ----------------------------------------------------------------------------
module tb_or3_reduce_seq;
    localparam int WIDTH = 32;
`ifdef OR3_REDUCE_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    or3_reduce_seq_if #(.WIDTH(WIDTH)) u_if ();

    or3_reduce_seq #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_value(input string tag, input int unsigned obs,
                             input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and complete the input handshake (edge E0).
    task automatic send(input logic [WIDTH-1:0] data);
        int wait_cyc;
        wait_cyc = 0;
        while (!u_if.in_ready && wait_cyc < 50) begin
            tick();
            wait_cyc++;
        end
        chk_value("send_ready", u_if.in_ready, 1);
        u_if.in_valid = 1'b1;
        u_if.in_data  = data;
        tick();
        u_if.in_valid = 1'b0;
        chk_value("accept_busy", u_if.busy, 1);
        chk_value("accept_in_ready", u_if.in_ready, 0);
    endtask

    // Count edges from E0 until out_valid and compare the result.
    task automatic wait_result(input string tag, input int exp_lat,
                               input int exp_any, input int exp_first);
        int lat;
        lat = 0;
        while (!u_if.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk_value({tag, "_latency"}, lat, exp_lat);
        chk_value({tag, "_any"}, u_if.out_any, exp_any);
        chk_value({tag, "_first"}, u_if.out_first, exp_first);
    endtask

    // Output handshake with out_ready=1; block is idle on the next cycle.
    task automatic consume(input string tag);
        u_if.out_ready = 1'b1;
        tick();
        chk_value({tag, "_valid_drop"}, u_if.out_valid, 0);
        chk_value({tag, "_in_ready"}, u_if.in_ready, 1);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        u_if.in_valid  = 1'b0;
        u_if.in_data   = '0;
        u_if.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_value("rst_in_ready", u_if.in_ready, 1);
        chk_value("rst_out_valid", u_if.out_valid, 0);
        chk_value("rst_busy", u_if.busy, 0);
        chk_value("rst_out_any", u_if.out_any, 0);
        chk_value("rst_out_first", u_if.out_first, 0);
        rst = 1'b0;
        tick();

        // All zero: full scan in both builds
        send(32'h0000_0000);
        wait_result("zero", 11, 0, 0);
        consume("zero");

        // Lowest bit: chunk 0
        send(32'h0000_0001);
        wait_result("bit0", EE ? 1 : 11, 1, 0);
        consume("bit0");

        // Top bit: chunk 10 (bits 30..32, bit 32 is pad)
        send(32'h8000_0000);
        wait_result("bit31", 11, 1, 10);
        consume("bit31");

        // Back-to-back words: chunk 1 then chunk 2
        send(32'h0000_0030);
        wait_result("b2b_a", EE ? 2 : 11, 1, 1);
        consume("b2b_a");
        send(32'h0000_0240);
        wait_result("b2b_b", EE ? 3 : 11, 1, 2);
        consume("b2b_b");

        // Backpressure in DONE while a new word is offered
        u_if.out_ready = 1'b0;
        send(32'h0000_0100);
        wait_result("hold", EE ? 3 : 11, 1, 2);
        u_if.in_valid = 1'b1;
        u_if.in_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_value("hold_valid", u_if.out_valid, 1);
            chk_value("hold_any", u_if.out_any, 1);
            chk_value("hold_first", u_if.out_first, 2);
            chk_value("hold_in_ready", u_if.in_ready, 0);
        end
        consume("hold_release");
        tick();
        u_if.in_valid = 1'b0;
        chk_value("hold_next_busy", u_if.busy, 1);
        wait_result("ones", EE ? 1 : 11, 1, 0);
        consume("ones");

        // Asynchronous reset in the middle of a scan
        send(32'h0000_0400);
        repeat (3) tick();
        chk_value("pre_rst_busy", u_if.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_value("mid_rst_out_valid", u_if.out_valid, 0);
        chk_value("mid_rst_busy", u_if.busy, 0);
        chk_value("mid_rst_in_ready", u_if.in_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        send(32'h0000_0400);
        wait_result("after_rst", EE ? 4 : 11, 1, 3);
        consume("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
